// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter
//
// Debounces N_BTN raw active-low push-buttons using one shared sample-tick prescaler and
// per-button stability counters. Debounced edges become press/release events (and, when
// BTN_AUTOREPEAT_EN is defined, auto-repeat events). A round-robin arbiter serialises the
// per-button pending events onto a single registered valid/ready stream.
//
// Optional feature macro: BTN_AUTOREPEAT_EN (adds per-button repeat counters).
//
// Ports:
//   clk_i        clock
//   rst_i        asynchronous active-high reset
//   btn_i        raw buttons, active-low, asynchronous to clk_i
//   state_o      debounced levels, 1 = pressed
//   evt_valid_o  event available
//   evt_ready_i  consumer accepts the current event
//   evt_id_o     button index of the current event
//   evt_kind_o   00 press, 01 release, 10 repeat
//   ovf_o        sticky: a pending event was overwritten before it was sent

module btn_event_arbiter #(
    parameter int unsigned N_BTN         = 4,
    parameter int unsigned TICK_DIV      = 50000,
    parameter int unsigned STABLE_TICKS  = 3,
    parameter int unsigned REPEAT_DELAY  = 500,
    parameter int unsigned REPEAT_PERIOD = 100,
    parameter int unsigned ID_W          = $clog2(N_BTN)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [N_BTN-1:0] btn_i,
    output logic [N_BTN-1:0] state_o,
    output logic             evt_valid_o,
    input  logic             evt_ready_i,
    output logic [ID_W-1:0]  evt_id_o,
    output logic [1:0]       evt_kind_o,
    output logic             ovf_o
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);
    localparam int unsigned CNT_W = $clog2(STABLE_TICKS + 1);

    localparam logic [1:0] KIND_PRESS   = 2'b00;
    localparam logic [1:0] KIND_RELEASE = 2'b01;
    localparam logic [1:0] KIND_REPEAT  = 2'b10;

    // ------------------------------------------------------------------------------------
    // Input synchroniser; resets to the released level so reset never looks like a press.
    // ------------------------------------------------------------------------------------
    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [N_BTN-1:0] s;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
        end
    end

    assign s = ~sync2_q;

    // ------------------------------------------------------------------------------------
    // Shared sample-tick prescaler
    // ------------------------------------------------------------------------------------
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;

    always_comb begin
        tick  = (div_q == DIV_W'(TICK_DIV - 1));
        div_d = tick ? '0 : div_q + DIV_W'(1);
    end

    // ------------------------------------------------------------------------------------
    // Per-button stability counters
    // ------------------------------------------------------------------------------------
    logic [N_BTN-1:0]            state_q, state_d;
    logic [N_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [N_BTN-1:0]            toggle;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        toggle  = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (tick) begin
                if (s[i] == state_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_W'(STABLE_TICKS - 1)) begin
                    toggle[i]  = 1'b1;
                    state_d[i] = ~state_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------------------
    // Auto-repeat
    // ------------------------------------------------------------------------------------
    logic [N_BTN-1:0] rep_evt;

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RC_W = $clog2(REPEAT_DELAY + 1);

    logic [N_BTN-1:0][RC_W-1:0] rc_q, rc_d;

    // The event fires on the tick that brings rc to REPEAT_DELAY; rc reloads instead of
    // reaching it, so later repeats follow every REPEAT_PERIOD ticks.
    always_comb begin
        rc_d    = rc_q;
        rep_evt = '0;
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (toggle[i] || !state_q[i]) begin
                rc_d[i] = '0;
            end else if (tick) begin
                if (rc_q[i] == RC_W'(REPEAT_DELAY - 1)) begin
                    rep_evt[i] = 1'b1;
                    rc_d[i]    = RC_W'(REPEAT_DELAY - REPEAT_PERIOD);
                end else begin
                    rc_d[i] = rc_q[i] + RC_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rc_q <= '0;
        end else begin
            rc_q <= rc_d;
        end
    end
`else
    assign rep_evt = '0;
`endif

    // ------------------------------------------------------------------------------------
    // Pending events and round-robin output register
    // ------------------------------------------------------------------------------------
    logic [N_BTN-1:0]       new_evt;
    logic [N_BTN-1:0][1:0]  new_kind;
    logic [N_BTN-1:0]       pend_q, pend_d;
    logic [N_BTN-1:0][1:0]  pkind_q, pkind_d;
    logic [N_BTN-1:0]       clr;
    logic                   ovf_q, ovf_d;
    logic                   valid_q, valid_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [1:0]             kind_q, kind_d;
    logic [ID_W-1:0]        rr_q, rr_d;
    logic                   load;
    logic                   found;
    logic [ID_W-1:0]        gnt_idx;

    always_comb begin
        for (int unsigned i = 0; i < N_BTN; i++) begin
            new_evt[i]  = toggle[i] | rep_evt[i];
            // A level toggle always outranks a repeat raised on the same tick.
            new_kind[i] = toggle[i] ? (state_q[i] ? KIND_RELEASE : KIND_PRESS) : KIND_REPEAT;
        end
    end

    // First pending button strictly after the last granted one, wrapping modulo N_BTN.
    always_comb begin
        int unsigned cand;
        cand    = 0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 1; k <= N_BTN; k++) begin
            cand = 32'(rr_q) + k;
            if (cand >= N_BTN) begin
                cand = cand - N_BTN;
            end
            if (!found && pend_q[cand[ID_W-1:0]]) begin
                found   = 1'b1;
                gnt_idx = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        load    = !valid_q || evt_ready_i;
        clr     = '0;
        valid_d = valid_q;
        id_d    = id_q;
        kind_d  = kind_q;
        rr_d    = rr_q;

        if (load) begin
            if (found) begin
                clr[gnt_idx] = 1'b1;
                valid_d      = 1'b1;
                id_d         = gnt_idx;
                kind_d       = pkind_q[gnt_idx];
                rr_d         = gnt_idx;
            end else begin
                valid_d = 1'b0;
            end
        end

        // A new event beats a same-cycle grant clear; only a still-pending event counts
        // as overwritten.
        pend_d = (pend_q & ~clr) | new_evt;
        ovf_d  = ovf_q | (|(new_evt & pend_q & ~clr));
        for (int unsigned i = 0; i < N_BTN; i++) begin
            pkind_d[i] = new_evt[i] ? new_kind[i] : pkind_q[i];
        end
    end

    // ------------------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q   <= '0;
            state_q <= '0;
            cnt_q   <= '0;
            pend_q  <= '0;
            pkind_q <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            id_q    <= '0;
            kind_q  <= KIND_PRESS;
            rr_q    <= ID_W'(N_BTN - 1);
        end else begin
            div_q   <= div_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            pkind_q <= pkind_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            kind_q  <= kind_d;
            rr_q    <= rr_d;
        end
    end

    assign state_o     = state_q;
    assign evt_valid_o = valid_q;
    assign evt_id_o    = id_q;
    assign evt_kind_o  = kind_q;
    assign ovf_o       = ovf_q;

endmodule

// File: doc/btn_event_arbiter.md
# btn_event_arbiter

Debounces N_BTN raw push-buttons with one shared tick prescaler and per-button stability counters. It turns debounced edges into press, release and (optionally) auto-repeat events. A round-robin arbiter serialises those events onto a single valid/ready event stream. The block sits between the board buttons and the lab control FSMs, and replaces per-button debouncer instances.

## Interface
- N_BTN, 4 — number of buttons, 2..16
- TICK_DIV, 50000 — clk_i cycles per sample tick (1 ms at 50 MHz), ≥2
- STABLE_TICKS, 3 — consecutive differing samples required to flip a debounced level, ≥1
- REPEAT_DELAY, 500 — ticks held before first repeat event
- REPEAT_PERIOD, 100 — ticks between subsequent repeat events
- ID_W, $clog2(N_BTN) — width of evt_id_o

- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- btn_i  in  N_BTN  raw buttons, active-low (0 = pressed), asynchronous
- state_o  out  N_BTN  debounced levels, 1 = pressed
- evt_valid_o  out  1  event available
- evt_ready_i  in  1  consumer accepts event
- evt_id_o  out  ID_W  button index of the event
- evt_kind_o  out  2  event kind: 00 press, 01 release, 10 repeat, 11 unused
- ovf_o  out  1  sticky flag: a pending event was overwritten before being sent

## Operation
- Each btn_i bit goes through a 2-flop synchroniser and is then inverted, giving s[i] (1 = pressed).
- Prescaler counts 0..TICK_DIV-1; tick is high for one cycle when the count equals TICK_DIV-1, then the count wraps to 0.
- Per-button counter cnt[i] (width $clog2(STABLE_TICKS+1)) is updated on tick only:
  - s[i]==state_o[i]: cnt[i] <= 0.
  - Otherwise cnt[i]+1; on the tick where cnt[i]==STABLE_TICKS-1, state_o[i] toggles and cnt[i] <= 0.
- A toggle of state_o[i] sets pend[i]=1 and pkind[i] to press (0→1) or release (1→0).
- If pend[i] is already 1 when a new event occurs for the same button:
  - pkind[i] is overwritten with the new kind;
  - ovf_o is set to 1 and stays 1 until reset.
- If a new event for button i coincides with pend[i] being cleared by a grant, the new event wins and pend[i] stays 1.
- Output register load:
  - Loads when evt_valid_o==0, or when evt_valid_o && evt_ready_i.
  - Source is the first set pend[] bit scanning upward from rr+1 modulo N_BTN.
  - On load, that pend bit clears, rr <= granted index, and evt_valid_o <= 1.
  - If no pend bit is set, evt_valid_o <= 0.
- While evt_valid_o && !evt_ready_i, evt_id_o and evt_kind_o are held stable.
- Reset state:
  - state_o = 0 (all released), cnt = 0, pend = 0, prescaler = 0.
  - rr = N_BTN-1, so index 0 has first priority.
  - evt_valid_o = 0, evt_id_o = 0, evt_kind_o = 0, ovf_o = 0.
- Reset mid-operation discards pending and in-flight events. No release event is generated for buttons held at reset.

## Timing
- The synchroniser adds 2 cycles.
- state_o updates at the clock edge of the qualifying tick.
- pend is set on that same edge.
- evt_valid_o rises on the next edge if the output register is free: latency 1 cycle after the state_o change.
- Worst-case press-to-state_o latency: 2 + STABLE_TICKS·TICK_DIV cycles.
- A button bouncing with period shorter than STABLE_TICKS ticks never flips state_o.
- Throughput: one event per cycle while evt_ready_i is held high.
- All outputs are registered; there is no combinational path from evt_ready_i to any output.

## Configuration
- BTN_AUTOREPEAT_EN defined:
  - Each button has a repeat counter rc[i], in ticks. It is cleared on any state_o[i] toggle and while state_o[i]==0.
  - While state_o[i]==1, rc[i] increments on each tick.
  - At rc[i]==REPEAT_DELAY, the block raises a repeat event (pkind=10, via pend with normal overwrite rules), and rc[i] reloads to REPEAT_DELAY-REPEAT_PERIOD.
  - As a result, repeat events follow every REPEAT_PERIOD ticks.
- BTN_AUTOREPEAT_EN undefined:
  - No repeat counters are synthesised.
  - evt_kind_o is never 10.
  - REPEAT_DELAY and REPEAT_PERIOD are ignored.

## Test plan
Parameters for all scenarios: N_BTN=4, TICK_DIV=4, STABLE_TICKS=3, REPEAT_DELAY=5, REPEAT_PERIOD=2.
- Reset held then released with btn_i=4'hF → state_o=0, evt_valid_o=0, ovf_o=0; no event for 100 cycles.
- btn_i[2] driven low and held, evt_ready_i=1 → state_o[2]=1 within 2+12 cycles; exactly one event: id=2, kind=00, valid high for 1 cycle.
- btn_i[1] toggling every 5 cycles for 200 cycles → state_o[1] stays 0 and no event is produced.
- Buttons 0, 1 and 3 pressed on the same cycle, evt_ready_i=0 for 50 cycles, then 1 → valid held with id=0 throughout the stall; events then delivered in order id 0, 1, 3, one per cycle.
- Button 0 pressed and released while evt_ready_i=0 and the output register is busy with another event → pending press overwritten by release; ovf_o=1; button 0 is later delivered as kind=01.
- With BTN_AUTOREPEAT_EN, button 3 held for 15 ticks → press event, then repeat events (kind=10) at ticks 5, 7, 9, 11, 13 and 15 after the state_o rise; without the macro, only the press event.
